// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 serialising lane mux.
package mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam int MAX_LANES = 64;
    localparam int IDX_W     = 6;

    typedef struct packed {
        logic             none;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic pick_t lowest_set(input logic [MAX_LANES-1:0] mask);
        pick_t r;
        r.none = 1'b1;
        r.idx  = '0;
        // Descending scan so the lowest set bit is the one left standing.
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.none = 1'b0;
                r.idx  = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lane_pick_nx1.sv
// Combinational priority selector: lowest pending lane, what remains, last flag.
module lane_pick_nx1
    import mux_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = $clog2(LANES)
) (
    input  logic [LANES-1:0]  mask,
    output logic [LANE_W-1:0] lane,
    output logic [LANES-1:0]  rem,
    output logic              is_last,
    output logic              none
);

    logic [MAX_LANES-1:0] wide;
    pick_t                pick;
    logic                 unused_idx;

    always_comb begin
        wide    = MAX_LANES'(mask);
        pick    = lowest_set(wide);
        lane    = pick.idx[LANE_W-1:0];
        none    = pick.none;
        rem     = mask;
        rem[lane] = 1'b0;
        is_last = (rem == '0);
    end

    assign unused_idx = ^pick.idx;

endmodule

// File: rtl/mux_nx1_serial.sv
// Serialises a group of LANES parallel lanes onto one WIDTH-bit stream,
// lane 0 first, with fixed-slot or skip-invalid timing chosen per group.
module mux_nx1_serial
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int LANES  = 4,
    localparam int LANE_W = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_valid,
    input  logic                   in_load,
    output logic                   in_ready,
    input  logic                   skip_en,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    output logic [LANE_W-1:0]      out_lane,
    output logic                   out_last
);

    state_e                 state_q, state_d;
    logic [LANES*WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]       valid_q, valid_d;
    logic [LANES-1:0]       pend_q, pend_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANE_W-1:0]      out_lane_q, out_lane_d;
    logic                   out_last_q, out_last_d;

    logic                   accept;
    logic                   advance;
    logic [LANES-1:0]       pick_mask;
    logic [LANES*WIDTH-1:0] src_data;
    logic [LANES-1:0]       src_valid;
    logic                   lane_v;

    logic [LANE_W-1:0]      pk_lane;
    logic [LANES-1:0]       pk_rem;
    logic                   pk_last;
    logic                   pk_none;

    // The slot on the output is the last one exactly when out_last_q is set,
    // which lets a new group land on the following edge with no bubble.
    assign in_ready = (state_q == ST_IDLE) | out_last_q;
    assign accept   = in_load & in_ready;
    assign advance  = (state_q == ST_SEND) & ~out_last_q;

    // Fixed mode walks every lane, so its pending set starts all-ones.
    assign pick_mask = accept ? (skip_en ? in_valid : {LANES{1'b1}})
                              : pend_q;
    assign src_data  = accept ? in_data  : data_q;
    assign src_valid = accept ? in_valid : valid_q;

    lane_pick_nx1 #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_pick (
        .mask    (pick_mask),
        .lane    (pk_lane),
        .rem     (pk_rem),
        .is_last (pk_last),
        .none    (pk_none)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = valid_q;
        pend_d      = pend_q;
        out_d       = '0;
        out_valid_d = 1'b0;
        out_lane_d  = '0;
        out_last_d  = 1'b0;
        lane_v      = src_valid[pk_lane];

        if (accept) begin
            data_d  = in_data;
            valid_d = in_valid;
        end

        if ((accept || advance) && !pk_none) begin
            state_d     = ST_SEND;
            pend_d      = pk_rem;
            out_valid_d = lane_v;
            out_lane_d  = pk_lane;
            out_last_d  = pk_last;
            if (lane_v) begin
                out_d = src_data[int'(pk_lane)*WIDTH +: WIDTH];
            end
        end else begin
            // Covers end of group and a skip-mode group with nothing valid.
            state_d = ST_IDLE;
            pend_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            valid_q     <= '0;
            pend_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_nx1_serial.sv
// Bench for mux_nx1_serial: directed 4-lane scenarios plus a randomised
// 16-bit x 8-lane run against a slot-queue reference model.
module tb_mux_nx1_serial;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [7:0]  lane;
        logic        last;
    } slot_t;

    localparam slot_t IDLE_S = '{v: 1'b0, d: 16'h0, lane: 8'h0, last: 1'b0};

    logic clk;
    logic reset;

    logic [31:0] in_data4;
    logic [3:0]  in_valid4;
    logic        in_load4;
    logic        in_ready4;
    logic        skip4;
    logic [7:0]  out4;
    logic        out_valid4;
    logic [1:0]  out_lane4;
    logic        out_last4;

    logic [127:0] in_data8;
    logic [7:0]   in_valid8;
    logic         in_load8;
    logic         in_ready8;
    logic         skip8;
    logic [15:0]  out8;
    logic         out_valid8;
    logic [2:0]   out_lane8;
    logic         out_last8;

    int tests;
    int fails;
    int vcnt4;

    slot_t q4[$];
    slot_t q8[$];
    slot_t cur4;
    slot_t cur8;

    mux_nx1_serial #(.WIDTH(8), .LANES(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_load   (in_load4),
        .in_ready  (in_ready4),
        .skip_en   (skip4),
        .out       (out4),
        .out_valid (out_valid4),
        .out_lane  (out_lane4),
        .out_last  (out_last4)
    );

    mux_nx1_serial #(.WIDTH(16), .LANES(8)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_load   (in_load8),
        .in_ready  (in_ready8),
        .skip_en   (skip8),
        .out       (out8),
        .out_valid (out_valid8),
        .out_lane  (out_lane8),
        .out_last  (out_last8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a falling edge: check this cycle, drive the next.
    task automatic step4(input logic ld, input logic [31:0] dat,
                         input logic [3:0] vm, input logic sk);
        logic rdy;
        int   hi;
        rdy = (q4.size() == 0);
        tests++;
        if (out4 !== cur4.d[7:0]) begin
            fails++;
            $display("FAIL out4 got %h exp %h", out4, cur4.d[7:0]);
        end
        tests++;
        if (out_valid4 !== cur4.v) begin
            fails++;
            $display("FAIL out_valid4 got %b exp %b", out_valid4, cur4.v);
        end
        tests++;
        if ({6'b0, out_lane4} !== cur4.lane) begin
            fails++;
            $display("FAIL out_lane4 got %0d exp %0d", out_lane4, cur4.lane);
        end
        tests++;
        if (out_last4 !== cur4.last) begin
            fails++;
            $display("FAIL out_last4 got %b exp %b", out_last4, cur4.last);
        end
        tests++;
        if (in_ready4 !== rdy) begin
            fails++;
            $display("FAIL in_ready4 got %b exp %b", in_ready4, rdy);
        end
        if (out_valid4 === 1'b1) vcnt4++;
        in_load4  = ld;
        in_data4  = dat;
        in_valid4 = vm;
        skip4     = sk;
        if (ld && rdy) begin
            hi = -1;
            for (int i = 0; i < 4; i++) if (vm[i]) hi = i;
            for (int i = 0; i < 4; i++) begin
                if (!sk)
                    q4.push_back('{v: vm[i],
                                   d: vm[i] ? {8'h0, dat[i*8 +: 8]} : 16'h0,
                                   lane: 8'(i), last: (i == 3)});
                else if (vm[i])
                    q4.push_back('{v: 1'b1, d: {8'h0, dat[i*8 +: 8]},
                                   lane: 8'(i), last: (i == hi)});
            end
        end
        cur4 = (q4.size() != 0) ? q4.pop_front() : IDLE_S;
        @(negedge clk);
    endtask

    task automatic step8(input logic ld, input logic [127:0] dat,
                         input logic [7:0] vm, input logic sk);
        logic rdy;
        int   hi;
        rdy = (q8.size() == 0);
        tests++;
        if (out8 !== cur8.d) begin
            fails++;
            $display("FAIL out8 got %h exp %h", out8, cur8.d);
        end
        tests++;
        if (out_valid8 !== cur8.v) begin
            fails++;
            $display("FAIL out_valid8 got %b exp %b", out_valid8, cur8.v);
        end
        tests++;
        if ({5'b0, out_lane8} !== cur8.lane) begin
            fails++;
            $display("FAIL out_lane8 got %0d exp %0d", out_lane8, cur8.lane);
        end
        tests++;
        if (out_last8 !== cur8.last) begin
            fails++;
            $display("FAIL out_last8 got %b exp %b", out_last8, cur8.last);
        end
        tests++;
        if (in_ready8 !== rdy) begin
            fails++;
            $display("FAIL in_ready8 got %b exp %b", in_ready8, rdy);
        end
        in_load8  = ld;
        in_data8  = dat;
        in_valid8 = vm;
        skip8     = sk;
        if (ld && rdy) begin
            hi = -1;
            for (int i = 0; i < 8; i++) if (vm[i]) hi = i;
            for (int i = 0; i < 8; i++) begin
                if (!sk)
                    q8.push_back('{v: vm[i],
                                   d: vm[i] ? dat[i*16 +: 16] : 16'h0,
                                   lane: 8'(i), last: (i == 7)});
                else if (vm[i])
                    q8.push_back('{v: 1'b1, d: dat[i*16 +: 16],
                                   lane: 8'(i), last: (i == hi)});
            end
        end
        cur8 = (q8.size() != 0) ? q8.pop_front() : IDLE_S;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({out4, out_valid4, out_lane4, out_last4} !== 12'h0) begin
            fails++;
            $display("FAIL reset_out4 got %h exp 0",
                     {out4, out_valid4, out_lane4, out_last4});
        end
        tests++;
        if ({out8, out_valid8, out_lane8, out_last8} !== 21'h0) begin
            fails++;
            $display("FAIL reset_out8 got %h exp 0",
                     {out8, out_valid8, out_lane8, out_last8});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        step4(1'b0, 32'h0, 4'h0, 1'b0);
        step8(1'b0, 128'h0, 8'h0, 1'b0);
    endtask

    task automatic test_fixed();
        step4(1'b1, 32'h44332211, 4'b1111, 1'b0);
        repeat (5) step4(1'b0, 32'h0, 4'h0, 1'b0);
        step4(1'b1, 32'h44332211, 4'b0101, 1'b0);
        repeat (5) step4(1'b0, 32'h0, 4'h0, 1'b1);
        step4(1'b1, 32'h44332211, 4'b0000, 1'b0);
        repeat (5) step4(1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_skip();
        step4(1'b1, 32'h44332211, 4'b1010, 1'b1);
        repeat (4) step4(1'b0, 32'h0, 4'h0, 1'b0);
        step4(1'b1, 32'hA5B6C7D8, 4'b1111, 1'b1);
        repeat (5) step4(1'b0, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++)
            step4(1'b1, 32'hDEADBEEF, 4'b0000, 1'b1);
        step4(1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        step4(1'b1, 32'h44332211, 4'b1111, 1'b0);
        vcnt4 = 0;
        repeat (4) step4(1'b1, 32'h88776655, 4'b1111, 1'b0);
        repeat (4) step4(1'b0, 32'h0, 4'h0, 1'b0);
        tests++;
        if (vcnt4 != 8) begin
            fails++;
            $display("FAIL b2b_valid_slots got %0d exp 8", vcnt4);
        end
        repeat (2) step4(1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        step4(1'b1, 32'h44332211, 4'b1111, 1'b0);
        step4(1'b0, 32'h0, 4'h0, 1'b0);
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({out4, out_valid4, out_lane4, out_last4} !== 12'h0) begin
            fails++;
            $display("FAIL async_reset got %h exp 0",
                     {out4, out_valid4, out_lane4, out_last4});
        end
        tests++;
        if (in_ready4 !== 1'b1) begin
            fails++;
            $display("FAIL async_reset_ready got %b exp 1", in_ready4);
        end
        @(negedge clk);
        reset = 1'b1;
        q4.delete();
        q8.delete();
        cur4 = IDLE_S;
        cur8 = IDLE_S;
        repeat (6) step4(1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_regression();
        logic [127:0] d;
        logic [7:0]   vm;
        for (int n = 0; n < 600; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       vm = 8'h00;
                1:       vm = 8'hFF;
                default: vm = 8'($urandom);
            endcase
            step8($urandom_range(0, 3) != 0, d, vm, 1'($urandom));
        end
        repeat (10) step8(1'b0, 128'h0, 8'h0, 1'b0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        vcnt4     = 0;
        cur4      = IDLE_S;
        cur8      = IDLE_S;
        in_data4  = '0;
        in_valid4 = '0;
        in_load4  = 1'b0;
        skip4     = 1'b0;
        in_data8  = '0;
        in_valid8 = '0;
        in_load8  = 1'b0;
        skip8     = 1'b0;
        reset     = 1'b0;
        test_reset();
        test_fixed();
        test_skip();
        test_back_to_back();
        test_reset_mid();
        test_regression();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_nx1_serial.md
Name: mux_nx1_serial

Overview:
- Parametrised, single-clock successor to the 4:1 byte-lane mux.
- Accepts a group of LANES parallel lanes (WIDTH bits each, per-lane valid) through a ready/load handshake.
- Serialises the group onto one WIDTH-bit output, one lane per clk cycle, lane 0 first.
- Sits between the lane-striped datapath and the serial byte stream of the PCIe PHY transmit path; adds per-lane tagging, last-lane marking and an optional invalid-lane skip mode.

Parameters:
- WIDTH, 8, bits per lane and width of out.
- LANES, 4, lanes per group; must be ≥2.
- LANE_W, $clog2(LANES), width of the lane index (derived, not overridden).

Ports:
- clk  input  1  root clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_data  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  LANES  per-lane valid mask for in_data.
- in_load  input  1  producer offers a group this cycle.
- in_ready  output  1  block can accept a group this cycle (combinational from state).
- skip_en  input  1  1 = skip invalid lanes, 0 = fixed-slot timing; sampled only at accept.
- out  output  WIDTH  serialised lane data.
- out_valid  output  1  out holds a valid lane.
- out_lane  output  LANE_W  source lane index of current slot.
- out_last  output  1  current slot is the final slot of its group.

Behaviour:
- Reset (reset=0, async):
  - out=0, out_valid=0, out_lane=0, out_last=0.
  - State=IDLE, hold registers cleared, in_ready=1 once reset releases.
  - A group in flight is discarded; no partial output after release.
- Accept:
  - A group is accepted on a rising edge where in_load=1 and in_ready=1.
  - in_data, in_valid and skip_en are captured into hold registers.
  - in_load while in_ready=0 is ignored; the producer must hold the group.
- Latency: the first slot of an accepted group appears on out in the cycle after the accept edge. All outputs are registered.
- States:
  - IDLE → SEND on accept, except skip mode with an all-zero mask.
  - SEND → SEND on accept at the last slot (back-to-back).
  - SEND → IDLE at the last slot with no accept.
- in_ready = (state==IDLE) OR (state==SEND AND the slot being driven this cycle is the last slot). This gives zero-bubble streaming.
- Fixed-slot mode (captured skip_en=0):
  - Exactly LANES slots, lane index 0..LANES-1 in order.
  - out_valid = captured in_valid[lane]; out = lane data when valid, else 0.
  - out_lane = slot index; out_last=1 on slot LANES-1.
- Skip mode (captured skip_en=1):
  - Emits only lanes whose captured valid bit is 1, in ascending lane order, one per cycle.
  - out_valid=1 on every emitted slot; out_lane = source lane; out_last=1 on the highest set lane.
  - Slot count = popcount(mask).
- All-zero mask:
  - Fixed mode: LANES slots with out_valid=0, out_last on the final slot.
  - Skip mode: group accepted and dropped, no slot emitted, state stays IDLE, in_ready stays 1.
- Idle cycles: out=0, out_valid=0, out_last=0, out_lane holds 0.
- skip_en changes mid-group have no effect on the group in progress.
- No arithmetic overflow: the lane pointer is bounded by LANES-1 and never wraps mid-group.

Decomposition:
- Shared package mux_pkg:
  - state encoding constants ST_IDLE, ST_SEND.
  - a function lowest_set(mask) returning the lowest set-bit index and a none-found flag.
- One sub-module is natural: lane_pick_nx1, a combinational priority selector (mask in → next lane index, remaining-mask, is_last). It is shared by both modes; fixed mode drives it with an all-ones mask.

Test Plan:
- Reset then fixed mode, LANES=4, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=4'b1111, single load → out 11,22,33,44 on cycles 1–4 after accept, out_lane 0..3, out_last only with 8'h44, in_ready=1 on cycle 4.
- Fixed mode, in_valid=4'b0101, same data → out 11,00,33,00; out_valid 1,0,1,0; out_last on slot 3.
- Skip mode, in_valid=4'b1010 → out 22 (lane 1), then 44 (lane 3, out_last=1), then idle. in_ready is 1 during the 44 slot.
- Back-to-back: in_load held 1 with groups A and B in fixed mode → 8 consecutive valid slots with no gap. Skip mode with mask 4'b0000 → no output and in_ready never drops.
- Assert reset low mid-group (after slot 1 of 4) → all outputs 0 asynchronously. After release, in_ready=1 and no residual slots appear.
- Regression with WIDTH=16, LANES=8, random masks and skip_en → output sequence matches a reference model slot-for-slot, including out_lane and out_last.
